// File: rtl/param_compute_unit_if.sv
// Instruction issue / result report bundle between the instruction source and param_compute_unit.
// The master is the instruction source; the slave is the compute unit.
interface param_compute_unit_if #(
    parameter int DATA_W = 8,
    parameter int REG_AW = 4
);
    logic              instr_valid;
    logic              instr_ready;
    logic [3:0]        instr_op;
    logic [REG_AW-1:0] instr_tgt;
    logic [REG_AW-1:0] instr_src0;
    logic [REG_AW-1:0] instr_src1;
    logic [DATA_W-1:0] instr_imm;
    logic              res_valid;
    logic [DATA_W-1:0] res_data;
    logic [REG_AW-1:0] res_tgt;
    logic              flag_zero;
    logic              flag_carry;
    logic              flag_illegal;

    modport master (
        output instr_valid, instr_op, instr_tgt, instr_src0, instr_src1, instr_imm,
        input  instr_ready, res_valid, res_data, res_tgt, flag_zero, flag_carry, flag_illegal
    );

    modport slave (
        input  instr_valid, instr_op, instr_tgt, instr_src0, instr_src1, instr_imm,
        output instr_ready, res_valid, res_data, res_tgt, flag_zero, flag_carry, flag_illegal
    );
endinterface

// File: rtl/param_compute_unit.sv
// Parametrised register-file compute unit: single-cycle ALU ops plus a
// shift-add multiply that takes DATA_W cycles, reporting each result with flags.
module param_compute_unit #(
    parameter int DATA_W = 8,
    parameter int REG_AW = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      ena,
    param_compute_unit_if.slave       bus,
    output logic                      busy,
    input  logic [REG_AW-1:0]         dbg_addr,
    output logic [DATA_W-1:0]         dbg_data
);
    localparam int NUM_REGS = 2 ** REG_AW;
    localparam int CNT_W    = $clog2(DATA_W);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DATA_W - 1);
    localparam logic [DATA_W-1:0] DW       = DATA_W'(DATA_W);

    typedef enum logic [3:0] {
        OP_NOP  = 4'd0,  OP_LOAD = 4'd1, OP_ADD = 4'd2, OP_SUB = 4'd3,
        OP_AND  = 4'd4,  OP_OR   = 4'd5, OP_NOT = 4'd6, OP_XOR = 4'd7,
        OP_SHL  = 4'd8,  OP_SHR  = 4'd9, OP_MUL = 4'd10
    } op_e;

    typedef enum logic {S_IDLE, S_MUL} state_e;

    state_e              state_q, state_d;
    logic [DATA_W-1:0]   regs [NUM_REGS];
    logic [DATA_W-1:0]   op_a, op_b;
    logic                accept;

    logic [DATA_W-1:0]   mul_a, mul_b, mul_acc, mul_sum;
    logic [CNT_W-1:0]    mul_cnt;
    logic [REG_AW-1:0]   mul_tgt;
    logic                mul_last;

    logic [DATA_W-1:0]   alu_res, sh_amt;
    logic [DATA_W:0]     alu_ext;
    logic                alu_carry, alu_carry_upd, alu_wr, alu_illegal;

    logic                res_valid_q, flag_zero_q, flag_carry_q, flag_illegal_q;
    logic [DATA_W-1:0]   res_data_q;
    logic [REG_AW-1:0]   res_tgt_q;

    assign bus.instr_ready  = ena & (state_q == S_IDLE);
    assign accept           = bus.instr_valid & bus.instr_ready;
    assign busy             = (state_q == S_MUL);
    assign dbg_data         = regs[dbg_addr];
    assign op_a             = regs[bus.instr_src0];
    assign op_b             = regs[bus.instr_src1];
    assign mul_sum          = mul_b[0] ? (mul_acc + mul_a) : mul_acc;
    assign mul_last         = (mul_cnt == CNT_LAST);

    assign bus.res_valid    = res_valid_q;
    assign bus.res_data     = res_data_q;
    assign bus.res_tgt      = res_tgt_q;
    assign bus.flag_zero    = flag_zero_q;
    assign bus.flag_carry   = flag_carry_q;
    assign bus.flag_illegal = flag_illegal_q;

    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
        alu_res       = '0;
        alu_ext       = '0;
        alu_carry     = 1'b0;
        alu_carry_upd = 1'b0;
        alu_wr        = 1'b1;
        alu_illegal   = 1'b0;
        sh_amt        = op_b % DW;
        case (op_e'(bus.instr_op))
            OP_NOP:  alu_wr = 1'b0;
            OP_LOAD: alu_res = bus.instr_imm;
            OP_ADD: begin
                alu_ext       = {1'b0, op_a} + {1'b0, op_b};
                alu_res       = alu_ext[DATA_W-1:0];
                alu_carry     = alu_ext[DATA_W];
                alu_carry_upd = 1'b1;
            end
            OP_SUB: begin
                alu_ext       = {1'b0, op_a} - {1'b0, op_b};
                alu_res       = alu_ext[DATA_W-1:0];
                alu_carry     = alu_ext[DATA_W];
                alu_carry_upd = 1'b1;
            end
            OP_AND:  alu_res = op_a & op_b;
            OP_OR:   alu_res = op_a | op_b;
            OP_NOT:  alu_res = ~op_a;
            OP_XOR:  alu_res = op_a ^ op_b;
            OP_SHL:  alu_res = op_a << sh_amt;
            OP_SHR:  alu_res = op_a >> sh_amt;
            OP_MUL:  alu_wr = 1'b0;
            default: begin
                alu_wr      = 1'b0;
                alu_illegal = 1'b1;
            end
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept && bus.instr_op == OP_MUL) state_d = S_MUL;
            S_MUL:   if (ena && mul_last) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses <= so every flop samples pre-edge values.
        if (!rst_n)   state_q <= S_IDLE;
        else if (ena) state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // NOTE: the register file is in reset because every register must read zero afterwards.
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
            res_valid_q    <= 1'b0;
            res_data_q     <= '0;
            res_tgt_q      <= '0;
            flag_zero_q    <= 1'b0;
            flag_carry_q   <= 1'b0;
            flag_illegal_q <= 1'b0;
            mul_a          <= '0;
            mul_b          <= '0;
            mul_acc        <= '0;
            mul_cnt        <= '0;
            mul_tgt        <= '0;
        end else begin
            res_valid_q <= 1'b0;
            if (accept) begin
                if (bus.instr_op == OP_MUL) begin
                    mul_a   <= op_a;
                    mul_b   <= op_b;
                    mul_acc <= '0;
                    mul_cnt <= '0;
                    mul_tgt <= bus.instr_tgt;
                end else begin
                    res_valid_q    <= 1'b1;
                    res_data_q     <= alu_res;
                    res_tgt_q      <= bus.instr_tgt;
                    flag_zero_q    <= (alu_res == '0);
                    flag_illegal_q <= alu_illegal;
                    if (alu_carry_upd) flag_carry_q <= alu_carry;
                    if (alu_wr) regs[bus.instr_tgt] <= alu_res;
                end
            end else if (ena && state_q == S_MUL) begin
                // One multiplier bit per cycle: add the shifted multiplicand when the bit is set.
                mul_acc <= mul_sum;
                mul_a   <= mul_a << 1;
                mul_b   <= mul_b >> 1;
                mul_cnt <= mul_cnt + 1'b1;
                if (mul_last) begin
                    regs[mul_tgt]  <= mul_sum;
                    res_valid_q    <= 1'b1;
                    res_data_q     <= mul_sum;
                    res_tgt_q      <= mul_tgt;
                    flag_zero_q    <= (mul_sum == '0);
                    flag_illegal_q <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_param_compute_unit.sv
// Self-checking bench for param_compute_unit: an 8-bit/16-register and a 16-bit/8-register
// instance, directed and randomized instructions checked against an arithmetic reference model.
module tb_param_compute_unit;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ena8 = 1'b1, ena16 = 1'b1;
    logic        busy8, busy16;
    logic [3:0]  dbg_addr8 = '0;
    logic [7:0]  dbg_data8;
    logic [2:0]  dbg_addr16 = '0;
    logic [15:0] dbg_data16;

    param_compute_unit_if #(.DATA_W(8),  .REG_AW(4)) bus8 ();
    param_compute_unit_if #(.DATA_W(16), .REG_AW(3)) bus16 ();

    param_compute_unit #(.DATA_W(8), .REG_AW(4)) dut8 (
        .clk(clk), .rst_n(rst_n), .ena(ena8), .bus(bus8),
        .busy(busy8), .dbg_addr(dbg_addr8), .dbg_data(dbg_data8)
    );

    param_compute_unit #(.DATA_W(16), .REG_AW(3)) dut16 (
        .clk(clk), .rst_n(rst_n), .ena(ena16), .bus(bus16),
        .busy(busy16), .dbg_addr(dbg_addr16), .dbg_data(dbg_data16)
    );

    always #5 clk = ~clk;

    int          total = 0;
    int          bad = 0;
    logic [31:0] ref_r [2][16];
    logic        ref_c [2];
    logic        o_valid, o_ready, o_busy, o_zero, o_carry, o_ill;
    logic [31:0] o_data, o_tgt;

    // Reference model: plain integer arithmetic modulo 2**width.
    function automatic void predict(input bit u, input logic [3:0] op, input int s0, s1,
                                    input logic [31:0] imm, output logic [31:0] res,
                                    output bit wr, output bit ill, output bit carry);
        int w;
        longint m, a, b, s;
        w = u ? 16 : 8;
        m = (longint'(1) << w) - 1;
        a = longint'(ref_r[u][s0]);
        b = longint'(ref_r[u][s1]);
        carry = ref_c[u];
        wr = 1'b1;
        ill = 1'b0;
        s = 0;
        case (op)
            4'd0:  begin s = 0; wr = 1'b0; end
            4'd1:  s = longint'(imm) & m;
            4'd2:  begin s = a + b; carry = (s > m); s = s & m; end
            4'd3:  begin carry = (a < b); s = (a - b) & m; end
            4'd4:  s = a & b;
            4'd5:  s = a | b;
            4'd6:  s = ~a & m;
            4'd7:  s = a ^ b;
            4'd8:  s = (a << (b % w)) & m;
            4'd9:  s = a >> (b % w);
            4'd10: s = (a * b) & m;
            default: begin s = 0; wr = 1'b0; ill = 1'b1; end
        endcase
        res = s[31:0];
    endfunction

    function automatic void clear_model();
        for (int u = 0; u < 2; u++) begin
            for (int r = 0; r < 16; r++) ref_r[u][r] = '0;
            ref_c[u] = 1'b0;
        end
    endfunction

    task automatic drive(input bit u, input bit v, input logic [3:0] op, input int tgt, s0, s1,
                         input logic [31:0] imm);
        if (!u) begin
            bus8.instr_valid = v;  bus8.instr_op = op;
            bus8.instr_tgt = tgt[3:0]; bus8.instr_src0 = s0[3:0]; bus8.instr_src1 = s1[3:0];
            bus8.instr_imm = imm[7:0];
        end else begin
            bus16.instr_valid = v; bus16.instr_op = op;
            bus16.instr_tgt = tgt[2:0]; bus16.instr_src0 = s0[2:0]; bus16.instr_src1 = s1[2:0];
            bus16.instr_imm = imm[15:0];
        end
    endtask

    task automatic sample(input bit u);
        if (!u) begin
            o_valid = bus8.res_valid;  o_ready = bus8.instr_ready; o_busy = busy8;
            o_data = 32'(bus8.res_data); o_tgt = 32'(bus8.res_tgt);
            o_zero = bus8.flag_zero; o_carry = bus8.flag_carry; o_ill = bus8.flag_illegal;
        end else begin
            o_valid = bus16.res_valid; o_ready = bus16.instr_ready; o_busy = busy16;
            o_data = 32'(bus16.res_data); o_tgt = 32'(bus16.res_tgt);
            o_zero = bus16.flag_zero; o_carry = bus16.flag_carry; o_ill = bus16.flag_illegal;
        end
    endtask

    task automatic read_reg(input bit u, input int r, output logic [31:0] v);
        if (!u) begin dbg_addr8 = r[3:0];  #1; v = 32'(dbg_data8);  end
        else    begin dbg_addr16 = r[2:0]; #1; v = 32'(dbg_data16); end
    endtask

    task automatic set_ena(input bit u, input logic e);
        if (!u) ena8 = e; else ena16 = e;
    endtask

    // Issue one instruction, wait for its result, and check every reported field.
    task automatic exec(input bit u, input logic [3:0] op, input int tgt, s0, s1,
                        input logic [31:0] imm, input int gap, input string tag);
        logic [31:0] exp_res, v, exp_reg;
        bit          wr, ill, exp_c;
        int          lat, exp_lat;
        predict(u, op, s0, s1, imm, exp_res, wr, ill, exp_c);
        exp_lat = (op == 4'd10) ? ((u ? 16 : 8) + gap) : 0;
        exp_reg = wr ? exp_res : ref_r[u][tgt];
        @(negedge clk);
        drive(u, 1'b1, op, tgt, s0, s1, imm);
        sample(u);
        total++; if (o_ready !== 1'b1) begin bad++; $display("FAIL %s ready_idle got %b want 1", tag, o_ready); end
        @(posedge clk); #1;
        drive(u, 1'b0, op, tgt, s0, s1, imm);
        sample(u);
        lat = 0;
        if (op == 4'd10) begin
            total++;
            if (o_busy !== 1'b1 || o_ready !== 1'b0) begin
                bad++; $display("FAIL %s mul_busy got busy=%b ready=%b want 1/0", tag, o_busy, o_ready);
            end
            while (o_valid !== 1'b1 && lat < 200) begin
                if (lat == 3 && gap > 0) begin
                    set_ena(u, 1'b0);
                    repeat (gap) @(posedge clk);
                    #1 set_ena(u, 1'b1);
                    lat += gap;
                end
                @(posedge clk); #1;
                lat++;
                sample(u);
            end
        end
        total++; if (lat != exp_lat) begin bad++; $display("FAIL %s latency got %0d want %0d", tag, lat, exp_lat); end
        total++; if (o_valid !== 1'b1) begin bad++; $display("FAIL %s res_valid got %b want 1", tag, o_valid); end
        total++; if (o_data !== exp_res) begin bad++; $display("FAIL %s res_data got %h want %h", tag, o_data, exp_res); end
        if (wr) begin
            total++; if (o_tgt !== 32'(tgt)) begin bad++; $display("FAIL %s res_tgt got %0d want %0d", tag, o_tgt, tgt); end
        end
        total++; if (o_zero !== (exp_res == 0)) begin bad++; $display("FAIL %s flag_zero got %b want %b", tag, o_zero, exp_res == 0); end
        total++; if (o_ill !== ill) begin bad++; $display("FAIL %s flag_illegal got %b want %b", tag, o_ill, ill); end
        total++; if (o_carry !== exp_c) begin bad++; $display("FAIL %s flag_carry got %b want %b", tag, o_carry, exp_c); end
        read_reg(u, tgt, v);
        total++; if (v !== exp_reg) begin bad++; $display("FAIL %s reg[%0d] got %h want %h", tag, tgt, v, exp_reg); end
        if (wr) ref_r[u][tgt] = exp_res;
        ref_c[u] = exp_c;
    endtask

    task automatic test_reset();
        logic [31:0] v;
        rst_n = 1'b0; ena8 = 1'b1; ena16 = 1'b1;
        drive(0, 1'b0, 4'd0, 0, 0, 0, 0);
        drive(1, 1'b0, 4'd0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        clear_model();
        sample(0);
        total++;
        if (o_valid !== 1'b0 || o_data !== 0 || o_tgt !== 0 || o_busy !== 1'b0 ||
            o_zero !== 1'b0 || o_carry !== 1'b0 || o_ill !== 1'b0 || o_ready !== 1'b1) begin
            bad++; $display("FAIL reset_outputs got v=%b d=%h t=%0d busy=%b z=%b c=%b i=%b rdy=%b want all 0, rdy=1",
                            o_valid, o_data, o_tgt, o_busy, o_zero, o_carry, o_ill, o_ready);
        end
        for (int r = 0; r < 16; r++) begin
            read_reg(0, r, v);
            total++; if (v !== 0) begin bad++; $display("FAIL reset_reg8[%0d] got %h want 0", r, v); end
        end
        for (int r = 0; r < 8; r++) begin
            read_reg(1, r, v);
            total++; if (v !== 0) begin bad++; $display("FAIL reset_reg16[%0d] got %h want 0", r, v); end
        end
    endtask

    task automatic test_load();
        exec(0, 4'd1, 3, 0, 0, 32'h05, 0, "load_r3");
        exec(0, 4'd1, 4, 0, 0, 32'h0A, 0, "load_r4");
    endtask

    task automatic test_add_sub();
        logic [31:0] v;
        exec(0, 4'd2, 5, 3, 4, 0, 0, "add_r5");
        read_reg(0, 5, v);
        total++; if (v !== 32'h0F) begin bad++; $display("FAIL add_r5_const got %h want 0f", v); end
        exec(0, 4'd1, 6, 0, 0, 32'hFF, 0, "load_r6");
        exec(0, 4'd2, 7, 6, 3, 0, 0, "add_carry_r7");
        read_reg(0, 7, v);
        total++; if (v !== 32'h04 || o_carry !== 1'b1) begin bad++; $display("FAIL add_r7_const got %h c=%b want 04 c=1", v, o_carry); end
        exec(0, 4'd3, 8, 3, 4, 0, 0, "sub_borrow_r8");
        read_reg(0, 8, v);
        total++; if (v !== 32'hFB) begin bad++; $display("FAIL sub_r8_const got %h want fb", v); end
        exec(0, 4'd3, 9, 3, 3, 0, 0, "sub_zero_r9");
    endtask

    task automatic test_mul();
        logic [31:0] v;
        exec(0, 4'd10, 10, 4, 3, 0, 0, "mul_r10");
        read_reg(0, 10, v);
        total++; if (v !== 32'h32) begin bad++; $display("FAIL mul_r10_const got %h want 32", v); end
        exec(0, 4'd1, 13, 0, 0, 32'hFF, 0, "load_r13");
        exec(0, 4'd10, 13, 13, 13, 0, 0, "mul_ff_self");
        read_reg(0, 13, v);
        total++; if (v !== 32'h01) begin bad++; $display("FAIL mul_ff_const got %h want 01", v); end
    endtask

    task automatic test_shift_logic();
        logic [31:0] v;
        exec(0, 4'd8, 11, 3, 4, 0, 0, "shl_r11");
        read_reg(0, 11, v);
        total++; if (v !== 32'h14) begin bad++; $display("FAIL shl_r11_const got %h want 14", v); end
        exec(0, 4'd6, 12, 3, 0, 0, 0, "not_r12");
        read_reg(0, 12, v);
        total++; if (v !== 32'hFA) begin bad++; $display("FAIL not_r12_const got %h want fa", v); end
        exec(0, 4'd7, 2, 3, 4, 0, 0, "xor_r2");
        exec(0, 4'd9, 1, 6, 3, 0, 0, "shr_r1");
        exec(0, 4'd4, 14, 6, 4, 0, 0, "and_r14");
        exec(0, 4'd5, 15, 3, 4, 0, 0, "or_r15");
    endtask

    task automatic test_illegal();
        logic [31:0] held;
        exec(0, 4'd13, 3, 4, 4, 0, 0, "illegal_13");
        exec(0, 4'd0, 5, 0, 0, 0, 0, "nop");
        held = o_data;
        @(posedge clk); #1 sample(0);
        total++; if (o_valid !== 1'b0 || o_data !== held) begin
            bad++; $display("FAIL idle_hold got v=%b d=%h want v=0 d=%h", o_valid, o_data, held);
        end
    endtask

    task automatic test_ena_stall();
        exec(0, 4'd10, 15, 6, 4, 0, 3, "mul_ena_gap");
    endtask

    task automatic test_back_to_back();
        exec(0, 4'd1, 1, 0, 0, 32'h01, 0, "b2b_seed");
        for (int i = 0; i < 6; i++) exec(0, 4'd2, 1, 1, 1, 0, 0, "b2b_chain");
    endtask

    task automatic test_random();
        logic [3:0] op;
        for (int r = 0; r < 16; r++) exec(0, 4'd1, r, 0, 0, $urandom, 0, "rand_seed");
        for (int i = 0; i < 80; i++) begin
            op = 4'($urandom_range(0, 15));
            exec(0, op, $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15),
                 $urandom, (op == 4'd10 && i % 3 == 0) ? 2 : 0, "rand8");
        end
    endtask

    task automatic test_reset_mid_mul();
        logic [31:0] v;
        int pulses;
        exec(0, 4'd1, 1, 0, 0, 32'h07, 0, "rm_ld1");
        exec(0, 4'd1, 2, 0, 0, 32'h09, 0, "rm_ld2");
        exec(0, 4'd1, 5, 0, 0, 32'h55, 0, "rm_ld5");
        @(negedge clk); drive(0, 1'b1, 4'd10, 5, 1, 2, 0);
        @(posedge clk); #1 drive(0, 1'b0, 4'd0, 0, 0, 0, 0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        clear_model();
        sample(0);
        total++; if (o_busy !== 1'b0 || o_valid !== 1'b0) begin
            bad++; $display("FAIL rm_busy got busy=%b v=%b want 0/0", o_busy, o_valid);
        end
        pulses = 0;
        repeat (12) begin @(posedge clk); #1 sample(0); if (o_valid === 1'b1) pulses++; end
        total++; if (pulses != 0) begin bad++; $display("FAIL rm_no_result got %0d pulses want 0", pulses); end
        read_reg(0, 5, v);
        total++; if (v !== 0) begin bad++; $display("FAIL rm_tgt got %h want 0", v); end
    endtask

    task automatic test_wide();
        logic [3:0] op;
        exec(1, 4'd1, 1, 0, 0, 32'h1234, 0, "w_ld1");
        exec(1, 4'd1, 2, 0, 0, 32'hEDCC, 0, "w_ld2");
        exec(1, 4'd2, 3, 1, 2, 0, 0, "w_add_wrap");
        total++; if (o_data !== 0 || o_carry !== 1'b1 || o_zero !== 1'b1) begin
            bad++; $display("FAIL w_add_const got d=%h c=%b z=%b want 0/1/1", o_data, o_carry, o_zero);
        end
        exec(1, 4'd10, 4, 1, 2, 0, 0, "w_mul");
        exec(1, 4'd10, 5, 2, 2, 0, 2, "w_mul_gap");
        for (int i = 0; i < 20; i++) begin
            op = 4'($urandom_range(0, 15));
            exec(1, op, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
                 $urandom, 0, "rand16");
        end
    endtask

    initial begin
        test_reset();
        test_load();
        test_add_sub();
        test_mul();
        test_shift_logic();
        test_illegal();
        test_ena_stall();
        test_back_to_back();
        test_random();
        test_reset_mid_mul();
        test_wide();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/param_compute_unit.md
Name: param_compute_unit

Overview:
Parametrised successor of the team's 8-bit register-file compute unit. It has a configurable data width and register count, and accepts one instruction at a time over a valid/ready handshake. It executes single-cycle logic/arithmetic/shift ops and a multi-cycle shift-add multiply, then writes the result back and emits it with flags. It sits between the instruction source (pin/deserialiser logic) and the output drivers of the top-level tile.

Parameters:
DATA_W, 8, datapath and register width (>=4).
REG_AW, 4, register address width; register count = 2**REG_AW.

Ports:
clk  input  1  clock, all state on rising edge.
rst_n  input  1  reset, synchronous, active-low.
ena  input  1  global enable; when 0 all state holds and instr_ready=0.
instr_valid  input  1  instruction present.
instr_ready  output  1  unit can accept (combinational: ena & state==IDLE).
instr_op  input  4  opcode.
instr_tgt  input  REG_AW  target register.
instr_src0  input  REG_AW  source 0.
instr_src1  input  REG_AW  source 1.
instr_imm  input  DATA_W  immediate for LOAD.
res_valid  output  1  one-cycle pulse: result written.
res_data  output  DATA_W  result value.
res_tgt  output  REG_AW  register written.
flag_zero  output  1  res_data==0 for the reported result.
flag_carry  output  1  carry/borrow of the last ADD/SUB (sticky until next ADD/SUB).
flag_illegal  output  1  reported instruction had a reserved opcode.
busy  output  1  multiply in progress.
dbg_addr  input  REG_AW  debug read address.
dbg_data  output  DATA_W  combinational read of register[dbg_addr].

Behaviour:
- Reset (rst_n=0 at edge): all 2**REG_AW registers=0, state=IDLE, res_valid=0, res_data=0, res_tgt=0, all flags=0, busy=0. Reset overrides ena and aborts any in-flight multiply with no write.
- Accept = instr_valid & instr_ready at a rising edge. Sources are read at the accept edge.
- Opcodes:
  - 0 NOP: no write; res_valid=1, res_data=0.
  - 1 LOAD: R[tgt]=imm.
  - 2 ADD: R[tgt]=R[src0]+R[src1]; carry=bit DATA_W of the sum.
  - 3 SUB: R[tgt]=R[src0]-R[src1]; carry=1 when borrow (src0<src1, unsigned).
  - 4 AND, 5 OR, 7 XOR: bitwise on src0/src1.
  - 6 NOT: R[tgt]=~R[src0].
  - 8 SHL: R[src0] << (R[src1] mod DATA_W), zero fill.
  - 9 SHR: R[src0] >> (R[src1] mod DATA_W), logical.
  - 10 MUL: low DATA_W bits of unsigned R[src0]*R[src1].
  - 11-15 reserved: no write; res_valid=1, flag_illegal=1, res_data=0.
- Single-cycle ops (all except MUL): the register write, res_* and flags all update on the accept edge, so res_valid is high in the cycle after accept. Back-to-back accepts are allowed every cycle. A following instruction sees the new value; there is no hazard.
- MUL FSM: IDLE -> MUL on accept. Operands and tgt are latched. Shift-add runs one bit per cycle for DATA_W cycles; busy=1 and instr_ready=0 throughout. On the DATA_W-th edge the unit writes R[tgt], pulses res_valid and returns to IDLE. Latency from accept edge to result edge is DATA_W cycles. ena=0 freezes the counter and does not cancel. Sources are latched, so tgt==src is safe.
- Flags: flag_zero and flag_illegal are reported with every res_valid and hold afterwards. flag_carry changes only on ADD/SUB.
- res_valid=0 in any cycle with no completing instruction. Other res_* outputs hold.
- tgt may equal src0/src1: the old value is used.

Test Plan:
- Reset, then LOAD R3=0x05 and LOAD R4=0x0A -> res_valid pulses, dbg R3=0x05, R4=0x0A, and after reset every register reads 0 including R15.
- ADD R5=R3+R4 -> 0x0F, carry=0; LOAD R6=0xFF, then ADD R7=R6+R3 -> 0x04, carry=1; SUB R8=R3-R4 -> 0xFB, carry=1; SUB R9=R3-R3 -> 0x00, zero=1.
- MUL R10=R4*R3 (0x0A*0x05) -> busy for 8 cycles, instr_ready=0, res_valid on cycle 8, R10=0x32. Then 0xFF*0xFF -> 0x01.
- SHL R11=R3<<R4 (shift 10 mod 8=2) -> 0x14; NOT R12=~R3 -> 0xFA; XOR R3,R4 -> 0x0F; reserved op 13 -> flag_illegal=1 and no register changes.
- Drop ena mid-MUL for 3 cycles -> result arrives 3 cycles later and is correct. Assert rst_n=0 mid-MUL -> no write to the target and busy=0.
- Rerun with DATA_W=16, REG_AW=3: 0x1234+0xEDCC -> 0x0000 with carry=1 and zero=1; MUL completes in 16 cycles.
